// File: rtl/bru_pkg.sv
// Shared types for the branch resolve unit: FSM states, in-flight entry,
// widths and a saturating counter helper.
package bru_pkg;

    localparam int PC_W_DEF = 10;
    localparam int PC_MAX_W = 32;
    localparam int AGE_W    = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOOKUP    = 2'd1,
        WAIT_PRED = 2'd2
    } bru_state_e;

    typedef struct packed {
        logic [PC_MAX_W-1:0] pc;
        logic                taken;
        logic                pred;
        logic [AGE_W-1:0]    age;
    } bru_entry_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v,
                                              input logic        en);
        return (en && v != 16'hFFFF) ? v + 16'd1 : v;
    endfunction

endpackage

// File: rtl/bru_fifo.sv
// In-order queue of in-flight branches; every entry ages each cycle,
// saturating at MAX_AGE. Ports: push/din, pop, full/empty, head.
module bru_fifo
    import bru_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int MAX_AGE = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push_i,
    input  bru_entry_t din_i,
    input  logic       pop_i,
    output logic       full_o,
    output logic       empty_o,
    output bru_entry_t head_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_AGE);

    bru_entry_t       mem_q [DEPTH];
    logic [PTR_W-1:0] rd_q;
    logic [PTR_W-1:0] wr_q;
    logic [PTR_W:0]   cnt_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            // Ages of empty slots are don't-care; a push overwrites them.
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_q[i].age != AGE_MAX)
                    mem_q[i].age <= mem_q[i].age + AGE_W'(1);
            end
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + PTR_W'(1);
            end
            if (do_pop) rd_q <= rd_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + (PTR_W+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PTR_W+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: accepts trace records, looks up the predictor,
// queues the prediction and issues in-order updates RESOLVE_LAT cycles
// later. Ports: rec_* (record in), lookup_*/pred_* (predictor lookup),
// upd_* (resolution), align_err, branch_count/mispredict_count.
// Define BRU_STATS_EN to build the branch/mispredict counters.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int PC_W        = PC_W_DEF,
    parameter int DEPTH       = 4,
    parameter int RESOLVE_LAT = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            rec_valid,
    output logic            rec_ready,
    input  logic [PC_W-1:0] rec_pc,
    input  logic            rec_taken,
    output logic            lookup_valid,
    output logic [PC_W-1:0] lookup_pc,
    input  logic            pred_valid,
    input  logic            pred_taken,
    output logic            upd_valid,
    output logic [PC_W-1:0] upd_pc,
    output logic            upd_taken,
    output logic            upd_mispredict,
    output logic            align_err,
    output logic [15:0]     branch_count,
    output logic [15:0]     mispredict_count
);

    bru_state_e      state_q;
    logic [PC_W-1:0] pc_q;
    logic            taken_q;
    logic            align_err_q;
    logic            ready_en_q;
    logic            full;
    logic            empty;
    logic            accept;
    logic            push;
    logic            pop;
    bru_entry_t      din;
    bru_entry_t      head;
    logic            unused_head_pc;

    // ready_en_q holds rec_ready low for the first cycle after reset.
    // Accept requires a free slot, so the lookup in flight always fits.
    assign rec_ready = ready_en_q && (state_q == IDLE) && !full;
    assign accept    = rec_valid && rec_ready;
    assign push      = (state_q == WAIT_PRED) && pred_valid;
    assign pop       = !empty && (head.age == AGE_W'(RESOLVE_LAT));

    always_comb begin
        din       = '0;
        din.pc    = PC_MAX_W'(pc_q);
        din.taken = taken_q;
        din.pred  = pred_taken;
        din.age   = '0;
    end

    bru_fifo #(
        .DEPTH   (DEPTH),
        .MAX_AGE (RESOLVE_LAT)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .din_i   (din),
        .pop_i   (pop),
        .full_o  (full),
        .empty_o (empty),
        .head_o  (head)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            taken_q     <= 1'b0;
            align_err_q <= 1'b0;
            ready_en_q  <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (rec_pc[1:0] == 2'b00) begin
                            pc_q    <= rec_pc;
                            taken_q <= rec_taken;
                            state_q <= LOOKUP;
                        end else begin
                            align_err_q <= 1'b1;
                        end
                    end
                end
                LOOKUP:    state_q <= WAIT_PRED;
                WAIT_PRED: if (pred_valid) state_q <= IDLE;
                default:   state_q <= IDLE;
            endcase
        end
    end

    // lookup_pc stays on the latched PC until the prediction returns.
    assign lookup_valid   = (state_q == LOOKUP);
    assign lookup_pc      = (state_q != IDLE) ? pc_q : '0;
    assign align_err      = align_err_q;

    assign upd_valid      = pop;
    assign upd_pc         = pop ? head.pc[PC_W-1:0] : '0;
    assign upd_taken      = pop && head.taken;
    assign upd_mispredict = pop && (head.taken ^ head.pred);
    assign unused_head_pc = ^head.pc;

`ifdef BRU_STATS_EN
    logic [15:0] branch_cnt_q;
    logic [15:0] mispred_cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= sat_inc16(branch_cnt_q, pop);
            mispred_cnt_q <= sat_inc16(mispred_cnt_q, upd_mispredict);
        end
    end

    assign branch_count     = branch_cnt_q;
    assign mispredict_count = mispred_cnt_q;
`else
    assign branch_count     = '0;
    assign mispredict_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: scoreboard of expected
// updates, one task per scenario.
`timescale 1ns/1ps
module tb_branch_resolve_unit;

    localparam int PC_W  = 10;
    localparam int DEPTH = 4;
    localparam int LAT   = 15;
`ifdef BRU_STATS_EN
    localparam bit STATS = 1'b1;
    localparam int N_SAT = 65540;
`else
    localparam bit STATS = 1'b0;
    localparam int N_SAT = 24;
`endif

    logic            clock = 1'b0;
    logic            reset = 1'b0;
    logic            rec_valid = 1'b0;
    logic            rec_ready;
    logic [PC_W-1:0] rec_pc = '0;
    logic            rec_taken = 1'b0;
    logic            lookup_valid;
    logic [PC_W-1:0] lookup_pc;
    logic            pred_valid = 1'b0;
    logic            pred_taken = 1'b0;
    logic            upd_valid;
    logic [PC_W-1:0] upd_pc;
    logic            upd_taken;
    logic            upd_mispredict;
    logic            align_err;
    logic [15:0]     branch_count;
    logic [15:0]     mispredict_count;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic            taken;
        logic            mis;
        int              due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    branch_resolve_unit #(
        .PC_W        (PC_W),
        .DEPTH       (DEPTH),
        .RESOLVE_LAT (LAT)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .rec_valid        (rec_valid),
        .rec_ready        (rec_ready),
        .rec_pc           (rec_pc),
        .rec_taken        (rec_taken),
        .lookup_valid     (lookup_valid),
        .lookup_pc        (lookup_pc),
        .pred_valid       (pred_valid),
        .pred_taken       (pred_taken),
        .upd_valid        (upd_valid),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_mispredict   (upd_mispredict),
        .align_err        (align_err),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    // Scoreboard monitor: every update must match the oldest pending
    // branch and arrive exactly LAT cycles after its enqueue.
    always @(negedge clock) begin
        if (upd_valid) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL upd_unexpected: upd_pc=%h, none pending", upd_pc);
            end else begin
                mon_e = sb.pop_front();
                if (upd_pc !== mon_e.pc) begin
                    n_fail++;
                    $display("FAIL upd_pc: got %h want %h", upd_pc, mon_e.pc);
                end
                n_checks++;
                if (upd_taken !== mon_e.taken) begin
                    n_fail++;
                    $display("FAIL upd_taken: got %b want %b", upd_taken, mon_e.taken);
                end
                n_checks++;
                if (upd_mispredict !== mon_e.mis) begin
                    n_fail++;
                    $display("FAIL upd_mispredict: got %b want %b",
                             upd_mispredict, mon_e.mis);
                end
                n_checks++;
                if (cyc !== mon_e.due) begin
                    n_fail++;
                    $display("FAIL upd_latency: cycle %0d want %0d", cyc, mon_e.due);
                end
            end
        end else begin
            n_checks++;
            if ({upd_pc, upd_taken, upd_mispredict} !== '0) begin
                n_fail++;
                $display("FAIL upd_idle_zero: pc=%h t=%b m=%b want 0",
                         upd_pc, upd_taken, upd_mispredict);
            end
        end
    end

    task automatic send(input logic [PC_W-1:0] pc, input logic tk,
                        input logic pr);
        int w;
        w = 0;
        @(negedge clock);
        while (!rec_ready && w < 200) begin
            @(negedge clock);
            w++;
        end
        n_checks++;
        if (rec_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rec_ready_timeout: rec_ready=%b want 1", rec_ready);
            return;
        end
        rec_valid = 1'b1;
        rec_pc    = pc;
        rec_taken = tk;
        @(posedge clock);
        #1;
        rec_valid = 1'b0;
        if (pc[1:0] != 2'b00) return;
        @(negedge clock);
        n_checks++;
        if (lookup_valid !== 1'b1 || lookup_pc !== pc) begin
            n_fail++;
            $display("FAIL lookup: valid=%b pc=%h want 1 %h",
                     lookup_valid, lookup_pc, pc);
        end
        @(negedge clock);
        n_checks++;
        if (lookup_valid !== 1'b0 || lookup_pc !== pc) begin
            n_fail++;
            $display("FAIL lookup_hold: valid=%b pc=%h want 0 %h",
                     lookup_valid, lookup_pc, pc);
        end
        @(posedge clock);
        #1;
        pred_valid = 1'b1;
        pred_taken = pr;
        sb.push_back('{pc, tk, tk ^ pr, cyc + 1 + LAT});
        @(posedge clock);
        #1;
        pred_valid = 1'b0;
        pred_taken = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        while (sb.size() != 0 && w < 400) begin
            @(negedge clock);
            w++;
        end
        @(negedge clock);
        @(negedge clock);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: %0d pending want 0", sb.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        n_checks++;
        if ({rec_ready, lookup_valid, lookup_pc, upd_valid, align_err,
             branch_count, mispredict_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdy=%b lv=%b lpc=%h uv=%b ae=%b bc=%h mc=%h want 0",
                     rec_ready, lookup_valid, lookup_pc, upd_valid,
                     align_err, branch_count, mispredict_count);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (rec_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_after_release: got %b want 0", rec_ready);
        end
        @(negedge clock);
        n_checks++;
        if (rec_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_idle: got %b want 1", rec_ready);
        end
    endtask

    task automatic test_predict_hit();
        send(10'h010, 1'b1, 1'b1);
        wait_drain();
        n_checks++;
        if (branch_count !== (STATS ? 16'd1 : 16'd0) ||
            mispredict_count !== 16'd0) begin
            n_fail++;
            $display("FAIL hit_counts: bc=%0d mc=%0d want %0d 0",
                     branch_count, mispredict_count, STATS ? 1 : 0);
        end
    endtask

    task automatic test_mispredict();
        send(10'h024, 1'b0, 1'b1);
        wait_drain();
        n_checks++;
        if (branch_count !== (STATS ? 16'd2 : 16'd0) ||
            mispredict_count !== (STATS ? 16'd1 : 16'd0)) begin
            n_fail++;
            $display("FAIL mis_counts: bc=%0d mc=%0d want %0d %0d",
                     branch_count, mispredict_count,
                     STATS ? 2 : 0, STATS ? 1 : 0);
        end
    endtask

    task automatic test_align();
        send(10'h013, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            n_checks++;
            if (lookup_valid !== 1'b0 || align_err !== 1'b1) begin
                n_fail++;
                $display("FAIL align_drop: lv=%b ae=%b want 0 1",
                         lookup_valid, align_err);
            end
        end
        send(10'h040, 1'b1, 1'b0);
        wait_drain();
        n_checks++;
        if (align_err !== 1'b1) begin
            n_fail++;
            $display("FAIL align_sticky: got %b want 1", align_err);
        end
    endtask

    task automatic test_pred_ignored();
        @(posedge clock);
        #1;
        pred_valid = 1'b1;
        pred_taken = 1'b1;
        @(posedge clock);
        #1;
        pred_valid = 1'b0;
        pred_taken = 1'b0;
        for (int i = 0; i < LAT + 3; i++) begin
            @(negedge clock);
            n_checks++;
            if (upd_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL pred_ignored: upd_valid=%b want 0", upd_valid);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [PC_W-1:0] pcs [5];
        pcs = '{10'h100, 10'h104, 10'h108, 10'h10C, 10'h110};
        for (int i = 0; i < 4; i++) send(pcs[i], i[0], 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            n_checks++;
            if (rec_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL ready_full: got %b want 0", rec_ready);
            end
        end
        send(pcs[4], 1'b1, 1'b1);
        wait_drain();
    endtask

    task automatic test_reset_mid();
        send(10'h200, 1'b1, 1'b0);
        send(10'h204, 1'b0, 1'b0);
        @(negedge clock);
        rec_valid = 1'b1;
        rec_pc    = 10'h208;
        rec_taken = 1'b1;
        @(posedge clock);
        #1;
        rec_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        n_checks++;
        if (sb.size() != 2 || lookup_pc !== 10'h208) begin
            n_fail++;
            $display("FAIL mid_setup: pending=%0d lpc=%h want 2 208",
                     sb.size(), lookup_pc);
        end
        #1;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({rec_ready, lookup_valid, lookup_pc, upd_valid, upd_pc,
             align_err, branch_count, mispredict_count} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: rdy=%b lv=%b lpc=%h uv=%b ae=%b bc=%h want 0",
                     rec_ready, lookup_valid, lookup_pc, upd_valid,
                     align_err, branch_count);
        end
        sb.delete();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if (rec_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_ready_release: got %b want 0", rec_ready);
        end
        for (int i = 0; i < LAT + 10; i++) begin
            @(negedge clock);
            n_checks++;
            if (upd_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL mid_no_update: upd_valid=%b want 0", upd_valid);
            end
        end
        n_checks++;
        if (branch_count !== 16'd0 || mispredict_count !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_counts: bc=%0d mc=%0d want 0 0",
                     branch_count, mispredict_count);
        end
    endtask

    task automatic test_saturate();
        logic [15:0] want;
        for (int i = 0; i < N_SAT; i++)
            send({i[7:0], 2'b00}, 1'b0, 1'b1);
        wait_drain();
        want = STATS ? ((N_SAT > 65535) ? 16'hFFFF : 16'(N_SAT)) : 16'd0;
        n_checks++;
        if (branch_count !== want || mispredict_count !== want) begin
            n_fail++;
            $display("FAIL saturate: bc=%h mc=%h want %h", branch_count,
                     mispredict_count, want);
        end
    endtask

    initial begin
        test_reset();
        test_predict_hit();
        test_mispredict();
        test_align();
        test_pred_ignored();
        test_back_to_back();
        test_reset_mid();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter PC_W, default 10, branch PC width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, in-flight queue entries (power of two, 2..16).
REQ-003 SHALL have parameter RESOLVE_LAT, default 2, cycles from enqueue to update (1..15).
REQ-004 SHALL have port clock, input, 1, the single clock; all logic rises on posedge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port rec_valid, input, 1, trace record offered.
REQ-007 SHALL have port rec_ready, output, 1, record accepted when rec_valid && rec_ready at posedge.
REQ-008 SHALL have port rec_pc, input, PC_W, branch PC of record.
REQ-009 SHALL have port rec_taken, input, 1, actual outcome of record.
REQ-010 SHALL have port lookup_valid, output, 1, one-cycle predictor lookup strobe.
REQ-011 SHALL have port lookup_pc, output, PC_W, PC presented to predictor.
REQ-012 SHALL have port pred_valid, input, 1, predictor response strobe.
REQ-013 SHALL have port pred_taken, input, 1, predicted direction.
REQ-014 SHALL have port upd_valid, output, 1, one-cycle resolution strobe to predictor.
REQ-015 SHALL have port upd_pc, output, PC_W, resolved branch PC.
REQ-016 SHALL have port upd_taken, output, 1, actual outcome.
REQ-017 SHALL have port upd_mispredict, output, 1, prediction differed from outcome.
REQ-018 SHALL have port align_err, output, 1, sticky unaligned-PC flag.
REQ-019 SHALL have port branch_count, output, 16, resolved branches.
REQ-020 SHALL have port mispredict_count, output, 16, resolved mispredictions.

Function
REQ-021 SHALL run FSM IDLE -> LOOKUP -> WAIT_PRED -> IDLE.
REQ-022 SHALL assert rec_ready only in IDLE with queue not full.
REQ-023 SHALL, on accept with rec_pc[1:0]==0, latch pc/taken and enter LOOKUP.
REQ-024 SHALL, on accept with rec_pc[1:0]!=0, drop the record, set align_err, and stay IDLE.
REQ-025 SHALL, in LOOKUP, assert lookup_valid for exactly one cycle with lookup_pc = latched pc, then enter WAIT_PRED.
REQ-026 SHALL hold lookup_pc stable from LOOKUP until leaving WAIT_PRED.
REQ-027 SHALL, in WAIT_PRED on pred_valid, enqueue {pc, taken, pred_taken, age=0} and return to IDLE; pred_valid outside WAIT_PRED is ignored.
REQ-028 SHALL increment each entry's age every cycle, saturating at RESOLVE_LAT.
REQ-029 SHALL, when head age==RESOLVE_LAT, pop head and pulse upd_valid for one cycle with upd_pc, upd_taken, upd_mispredict = taken ^ pred.
REQ-030 SHALL resolve strictly in enqueue order, at most one update per cycle.
REQ-031 SHALL permit enqueue and pop in the same cycle; occupancy unchanged.
REQ-032 SHALL deassert rec_ready when full; an in-flight WAIT_PRED still completes (full check precedes accept, so a slot is reserved).
REQ-033 SHALL increment branch_count per update and mispredict_count per mispredicted update, both saturating at 16'hFFFF.
REQ-034 SHALL drive lookup_pc and upd_pc to 0 when their strobes are low.

Reset
REQ-035 SHALL, on reset low, immediately enter IDLE, empty queue, clear align_err and counters, and drive all outputs 0.
REQ-036 SHALL discard in-flight lookups and queued entries on reset mid-operation; no upd_valid until new records arrive after release.
REQ-037 SHALL keep rec_ready low while reset is asserted and in the first cycle after release.

Configuration
REQ-038 SHALL, with BRU_STATS_EN defined, implement branch_count and mispredict_count per REQ-033.
REQ-039 SHALL, without BRU_STATS_EN, tie both counters to 0 and remove their registers; all other behaviour unchanged.

Structure
REQ-040 SHALL place PC_W default, the state enum (IDLE, LOOKUP, WAIT_PRED) and the queue entry struct in package bru_pkg.
REQ-041 SHALL implement the in-order queue as sub-module bru_fifo (parameter DEPTH, push/pop/full/empty, head visible).

Verification
REQ-042 SHALL cover: record pc=0x010 taken=1, pred_taken=1 two cycles after lookup -> upd_valid RESOLVE_LAT cycles after enqueue, upd_mispredict=0, branch_count=1.
REQ-043 SHALL cover: pc=0x024 taken=0, pred_taken=1 -> upd_mispredict=1, mispredict_count=1.
REQ-044 SHALL cover: pc=0x013 -> no lookup_valid, align_err=1 and sticky until reset.
REQ-045 SHALL cover: RESOLVE_LAT=15, five back-to-back records, DEPTH=4 -> rec_ready low while full, updates in original PC order.
REQ-046 SHALL cover: reset asserted in WAIT_PRED with 2 queued -> outputs 0 immediately, no later upd_valid, counters 0.
REQ-047 SHALL cover: 65540 mispredicted branches with BRU_STATS_EN -> counters saturate at 0xFFFF; without BRU_STATS_EN -> counters remain 0.
